alu_arbiter: RTL
================

# alu_arbiter

Shares one 32-bit ALU between two requesters (requester 0: EX-stage SAD datapath, requester 1: address/loop-counter unit) with round-robin arbitration and valid/ready handshakes on both sides. Holds one operation in flight, runs single-cycle ops in one execute cycle and multiply over a configurable number of cycles, and returns a registered result tagged with the requester ID. It sits between the requesters and the ALU arithmetic core.

## Interface
- MUL_CYCLES, 3, execute cycles for multiply (legal range 1..15)
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- ReqValid  in  2  bit i = requester i presents an op
- ReqReady  out  2  bit i = requester i's op accepted this cycle
- ReqOp0, ReqOp1  in  4  opcode per requester
- ReqA0, ReqB0, ReqA1, ReqB1  in  32  operands per requester
- RespValid  out  1  result available
- RespReady  in  1  consumer takes result
- RespId  out  1  requester that issued the op
- RespResult  out  32  result
- RespZero  out  1  RespResult == 0
- RespErr  out  1  opcode was unsupported
- Busy  out  1  state != IDLE

## Operation
- Opcodes: 0000 add, 0001 sub, 0010 mul (low 32 bits of product), 0011 and, 0100 or, 0101 slt (signed; result 32'd1 or 32'd0). All others are illegal: RespResult=0, RespZero=1, RespErr=1.
- Add/sub wrap modulo 2^32; no overflow flag.
- FSM states IDLE, EXEC, MUL, RESP.
- IDLE: ReqReady is driven combinationally. If exactly one ReqValid is set, that requester is granted. If both are set, the requester other than LastGrant is granted. One-hot grant. On grant, latch op/A/B/ID and update LastGrant. Next state is MUL for op 0010, otherwise EXEC.
- EXEC: compute and register result/zero/err; next state RESP.
- MUL: counter loads MUL_CYCLES-1 on entry and decrements each cycle. When it reaches 0, register the product; next state RESP.
- RESP: RespValid=1. When RespReady=1, next state IDLE. ReqReady=0 in every state except IDLE.
- Dropping ReqValid before a grant has no effect. The requester must hold op/operands stable while ReqValid && !ReqReady.
- RespId/RespResult/RespZero/RespErr stay stable from the first RespValid cycle until the handshake.

## Timing
- Reset (async assert, sync release): state=IDLE, LastGrant=1 (requester 0 wins the first tie), counter=0. All outputs are 0: RespValid, RespId, RespResult, RespZero, RespErr, Busy, ReqReady.
- Accept edge = cycle 0.
  - Non-mul: RespValid first high in cycle 2.
  - Mul: RespValid first high in cycle 1+MUL_CYCLES.
- Minimum issue interval: 3 cycles (non-mul), 2+MUL_CYCLES (mul), with RespReady held high. No accept in the same cycle as a response handshake.
- Reset asserted mid-EXEC/MUL/RESP aborts the op. No response is produced and no ReqReady is given.
- RespReady high outside RESP is ignored.

## Structure
- Shared package alu_pkg holds the 4-bit opcode constants (OP_ADD..OP_SLT) and the state encoding constants. Existing ALU-control decode uses the same package.
- Sub-module alu_core is purely combinational: op, A, B → result, zero, err, covering all non-mul ops plus mul. The arbiter samples its mul output after MUL_CYCLES.
- Arbiter, FSM, counter and output registers live in alu_arbiter.

## Test plan
- Reset, then ReqValid=01, op add, A=5, B=7 → ReqReady=01 in cycle 0; RespValid in cycle 2 with RespResult=12, RespZero=0, RespId=0.
- Both valid every cycle: requester 0 sub 9−9, requester 1 or 0xF0|0x0F → grants alternate 0,1,0,1. Results are 0 with RespZero=1 (ID 0) and 0xFF (ID 1).
- MUL_CYCLES=3, mul 0x10000×0x10000 → RespValid in cycle 4, RespResult=0, RespZero=1. Mul 6×7 → 42.
- slt A=0xFFFFFFFF, B=1 → 1; slt A=1, B=0xFFFFFFFF → 0. Opcode 1111 → RespErr=1, RespResult=0.
- RespReady held low 5 cycles in RESP → outputs stable, ReqReady stays 00 despite ReqValid=11. Release RespReady → IDLE next cycle, then a new grant.
- Reset pulsed during MUL → all outputs 0 immediately. After release, a tie grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and arbiter state definitions
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Multiply is the only op that takes the multi-cycle path.
  function automatic logic op_is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 32-bit ALU arithmetic core
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        err
);

  // Opcode decode; unsupported opcodes yield zero with the error flag set.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      default: err    = 1'b1;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        id_q;
  logic [31:0] result_q;
  logic        zero_q, err_q;

  logic [1:0]  grant;
  logic        grant_id;
  logic [3:0]  grant_op;
  logic        accept;

  logic [31:0] core_result;
  logic        core_zero, core_err;

  alu_core u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .zero   (core_zero),
    .err    (core_err)
  );

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_id = grant[1];
  assign grant_op = grant_id ? req_op1 : req_op0;
  assign accept   = (state == ST_IDLE) && (req_valid != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; ready is held off while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      ST_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = rst_n ? grant : 2'b00;
          state_nxt = op_is_mul(grant_op) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_MUL:  if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on grant, multiply countdown, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      op_q       <= 4'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      id_q       <= 1'b0;
      result_q   <= 32'd0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= grant_op;
        a_q        <= grant_id ? req_a1 : req_a0;
        b_q        <= grant_id ? req_b1 : req_b0;
        id_q       <= grant_id;
        last_grant <= grant_id;
        cnt        <= 4'(MUL_CYCLES - 1);
      end
      if (state == ST_EXEC || (state == ST_MUL && cnt == 4'd0)) begin
        result_q <= core_result;
        zero_q   <= core_zero;
        err_q    <= core_err;
      end else if (state == ST_MUL) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign resp_valid  = (state == ST_RESP);
  assign busy        = (state != ST_IDLE);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;

endmodule
